// File: rtl/delay_pkg.sv
// Shared defaults and helpers for the note delay timer.
package delay_pkg;

    localparam int TICKS_DEF = 2;
    localparam int DUR_W_DEF = 11;

    function automatic int pre_w(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/note_delay_if.sv
// Run request / status bundle between a controller and the note delay timer.
interface note_delay_if
    import delay_pkg::*;
#(
    parameter int DUR_W = DUR_W_DEF
);

    logic [DUR_W-1:0] duration;
    logic             enabled;
    logic             active;
    logic             done;

    modport master (output duration, enabled, input active, done);
    modport slave  (input duration, enabled, output active, done);

endinterface

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every TICKS cycles, restarted from zero by clr.
module tick_gen
    import delay_pkg::*;
#(
    parameter int TICKS = TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = pre_w(TICKS);
    localparam logic [PW-1:0] LAST = PW'(TICKS - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/note_delay.sv
// Retriggerable-on-rise delay: active for duration*TICKS cycles, done on natural expiry.
module note_delay
    import delay_pkg::*;
#(
    parameter int TICKS = TICKS_DEF,
    parameter int DUR_W = DUR_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    note_delay_if.slave  bus
);

    logic             en_prev;
    logic             start;
    logic             tick;
    logic             clr;
    logic             active_q;
    logic             done_q;
    logic [DUR_W-1:0] units;

    assign start = bus.enabled && !en_prev;
    // Prescaler is held at zero whenever idle so a start always sees a full first unit.
    assign clr   = start || !active_q;

    tick_gen #(.TICKS(TICKS)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_prev  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            units    <= '0;
        end else begin
            en_prev <= bus.enabled;
            done_q  <= 1'b0;
            if (!bus.enabled) begin
                active_q <= 1'b0;
                units    <= '0;
            end else if (start) begin
                if (bus.duration == '0) begin
                    active_q <= 1'b0;
                    units    <= '0;
                    done_q   <= 1'b1;
                end else begin
                    active_q <= 1'b1;
                    units    <= bus.duration;
                end
            end else if (active_q && tick) begin
                if (units == DUR_W'(1)) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end
                units <= units - DUR_W'(1);
            end
        end
    end

    assign bus.active = active_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_note_delay.sv
// Randomized scoreboard bench for note_delay against a cycle-count reference model.
module tb_note_delay;
    import delay_pkg::*;

    localparam int TK = 2;
    localparam int DW = 11;

    typedef struct packed {
        logic active;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    note_delay_if #(.DUR_W(DW)) bus ();

    note_delay #(.TICKS(TK), .DUR_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #10 clk = ~clk;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   rem    = 0;   // model: cycles of active remaining
    bit   prev   = 1'b0;

    task automatic check(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, got, req, $time);
        end
    endtask

    // Expected outputs after the coming edge, from the behavioural rules.
    task automatic model_edge(input logic en, input logic [DW-1:0] dur);
        exp_t e;
        e.done = 1'b0;
        if (!en) begin
            rem = 0;
        end else if (!prev) begin
            if (dur == '0) e.done = 1'b1;
            rem = int'(dur) * TK;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) e.done = 1'b1;
        end
        prev     = en;
        e.active = (rem > 0);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic en, input logic [DW-1:0] dur);
        @(posedge clk);
        #5;
        bus.enabled  = en;
        bus.duration = dur;
        model_edge(en, dur);
    endtask

    task automatic run(input logic en, input logic [DW-1:0] dur, input int n);
        for (int i = 0; i < n; i++) step(en, dur);
    endtask

    task automatic reset_pulse(input logic en, input logic [DW-1:0] dur);
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        check("async_rst_active", bus.active, 1'b0);
        check("async_rst_done", bus.done, 1'b0);
        rem          = 0;
        prev         = 1'b0;
        bus.enabled  = en;
        bus.duration = dur;
        @(posedge clk);
        #5;
        rst_n = 1'b1;
        model_edge(en, dur);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("active", bus.active, e.active);
                check("done", bus.done, e.done);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin : stimulus
        logic            en_r;
        logic [DW-1:0]   dur_r;
        rst_n        = 1'b0;
        bus.enabled  = 1'b0;
        bus.duration = '0;
        #3;
        check("reset_active", bus.active, 1'b0);
        check("reset_done", bus.done, 1'b0);
        @(posedge clk);
        #5;
        rst_n = 1'b1;
        model_edge(1'b0, '0);

        run(1'b1, 11'd0, 4);
        run(1'b0, 11'd0, 2);

        run(1'b1, 11'd5, 13);
        run(1'b0, 11'd5, 2);

        run(1'b1, 11'd5, 3);
        run(1'b0, 11'd5, 3);

        run(1'b1, 11'd5, 1);
        run(1'b1, 11'd1, 12);
        run(1'b0, 11'd1, 2);

        run(1'b1, 11'd5, 31);
        run(1'b0, 11'd5, 1);
        run(1'b1, 11'd5, 12);
        run(1'b0, 11'd5, 2);

        run(1'b1, 11'd7, 5);
        reset_pulse(1'b1, 11'd7);
        run(1'b1, 11'd7, 16);
        run(1'b0, 11'd7, 2);

        en_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) en_r = ~en_r;
            dur_r = DW'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) reset_pulse(en_r, dur_r);
            else                            step(en_r, dur_r);
        end

        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size() == 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_delay.md
NOTE_DELAY -- requirements
Module: note_delay

Interface
REQ-001 Parameter TICKS, default 2: clock cycles per duration unit; legal range 1..65535.
REQ-002 Parameter DUR_W, default 11: width of the duration input.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 duration  input  DUR_W  requested delay length in units of TICKS clocks; sampled only at start.
REQ-006 enabled  input  1  run request; a 0->1 transition starts a delay, and a low level aborts it.
REQ-007 active  output  1  registered; high while a delay is running.
REQ-008 done  output  1  registered; one-cycle pulse on natural expiry.

Function
REQ-009 Start event SHALL be enabled==1 at a clock edge where the internally registered previous enabled value is 0.
- A level held high does not retrigger.
REQ-010 On a start event with duration=D>0, the block SHALL capture D and clear the prescaler.
- active SHALL be 1 after that same edge.
REQ-011 active SHALL remain high for exactly D*TICKS consecutive clock cycles, then fall.
REQ-012 Prescaler SHALL count 0..TICKS-1 and wrap; each wrap decrements the unit counter.
- active falls on the edge where the counter reaches 0.
REQ-013 done SHALL be 1 for exactly one cycle, coincident with the cycle in which active first reads 0 after natural expiry.
REQ-014 A start event with duration=0 SHALL leave active=0 and SHALL pulse done for one cycle on the next edge.
REQ-015 enabled low while active SHALL abort:
- active=0 after the next edge;
- counters cleared;
- no done pulse.
REQ-016 Start event and expiry on the same edge SHALL be resolved in favour of the start (restart with the new duration).
REQ-017 Changes to duration while active SHALL have no effect on the running delay.
REQ-018 After expiry with enabled still high, the block SHALL stay idle (active=0) until enabled falls and rises again.
REQ-019 Unit counter is DUR_W bits and the prescaler is ceil(log2(TICKS)) bits (minimum 1); no overflow is possible.

Reset
REQ-020 rst_n low SHALL immediately force:
- active=0 and done=0;
- prescaler=0 and unit counter=0;
- registered previous enabled=0.
REQ-021 Reset asserted mid-delay SHALL abort it.
- After release, enabled already high SHALL count as a start event on the first edge.

Structure
REQ-022 TICKS and DUR_W defaults SHALL reside in a shared package (delay_pkg) as localparams.
REQ-023 The prescaler SHALL be a sub-module tick_gen (parameter TICKS) with inputs clk, rst_n, clr and output tick.
- tick is a one-cycle pulse every TICKS cycles after clr.
REQ-024 The top level SHALL contain the edge detector, unit counter and output registers only.

Verification (clk period 20 ns, TICKS=2)
REQ-025 Reset then enabled=1 with duration=0 for 4 cycles -> active stays 0; done pulses once, 1 cycle after the rise.
REQ-026 enabled 0->1 with duration=5 -> active high for exactly 10 cycles, then done=1 for 1 cycle, then both 0.
REQ-027 duration=5 start, enabled low after 3 cycles -> active=0 one edge later; done never asserts.
REQ-028 duration=5 start, duration changed to 1 after 1 cycle -> active still high for exactly 10 cycles.
REQ-029 enabled held high after expiry for 20 cycles -> no second active pulse; after toggling enabled low then high -> new 10-cycle pulse.
REQ-030 rst_n pulsed low mid-delay (duration=7) -> active=0 asynchronously; with enabled high at release -> restart, active for 14 cycles.
